// File: rtl/frame_read_gen.sv
// frame_read_gen
//
// Reads a stored WIDTH x HEIGHT frame out of a synchronous frame RAM (1-cycle
// read latency) in raster order and returns it as a valid/ready pixel stream
// with start-of-frame, end-of-line and end-of-frame flags.
//
// A small return FIFO absorbs RAM latency. Reads are only issued while the
// FIFO has room for every read still in flight, so backpressure never loses
// data and the FIFO can never overflow.
//
// Ports:
//   clk_in          clock, all logic on the rising edge
//   rst_in          synchronous active-high reset
//   start_in        one-cycle pulse, starts a frame read when idle
//   rd_en_out       RAM read strobe
//   rd_addr_out     RAM read address (y*WIDTH + x), held when not reading
//   rd_data_in      RAM read data, valid the cycle after rd_en_out
//   pix_out         stream pixel (FIFO head)
//   pix_valid_out   stream valid
//   pix_ready_in    stream ready
//   sof_out         pixel is (0,0)
//   eol_out         pixel is the last of its line
//   eof_out         pixel is the last of the frame
//   x_index_out     x of pix_out
//   y_index_out     y of pix_out
//   busy_out        high while a frame is being read or drained
//   done_out        one-cycle pulse after the last pixel transfers

module frame_read_gen #(
    parameter int unsigned WIDTH      = 320,
    parameter int unsigned HEIGHT     = 240,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    output logic              rd_en_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    input  logic [DATA_W-1:0] rd_data_in,
    output logic [DATA_W-1:0] pix_out,
    output logic              pix_valid_out,
    input  logic              pix_ready_in,
    output logic              sof_out,
    output logic              eol_out,
    output logic              eof_out,
    output logic [ADDR_W-1:0] x_index_out,
    output logic [ADDR_W-1:0] y_index_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(HEIGHT - 1);
    localparam logic [CNT_W:0]    CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] x;
        logic [ADDR_W-1:0] y;
        logic              sof;
        logic              eol;
        logic              eof;
    } entry_t;

    state_e            state_q;
    logic [ADDR_W-1:0] x_q;
    logic [ADDR_W-1:0] y_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_addr_q;

    // Position/flags of the read currently travelling through the RAM.
    logic              inflight_q;
    logic [ADDR_W-1:0] fx_q;
    logic [ADDR_W-1:0] fy_q;
    logic              fsof_q;
    logic              feol_q;
    logic              feof_q;

    // Return FIFO.
    entry_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              is_sof;
    logic              is_eol;
    logic              is_eof;
    logic [CNT_W:0]    credit_used;
    logic              issue;
    logic              push;
    logic              pop;
    entry_t            head;

    // ------------------------------------------------------------------
    // Issue / FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        is_sof = (x_q == '0) && (y_q == '0);
        is_eol = (x_q == X_LAST);
        is_eof = is_eol && (y_q == Y_LAST);

        // Every outstanding read must already own a FIFO slot.
        credit_used = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inflight_q};
        issue       = (state_q == StRead) && (credit_used < CREDIT_MAX);

        push = inflight_q;
        pop  = (cnt_q != '0) && pix_ready_in;

        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM and read pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            last_addr_q <= '0;
            inflight_q  <= 1'b0;
            fx_q        <= '0;
            fy_q        <= '0;
            fsof_q      <= 1'b0;
            feol_q      <= 1'b0;
            feof_q      <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                fx_q        <= x_q;
                fy_q        <= y_q;
                fsof_q      <= is_sof;
                feol_q      <= is_eol;
                feof_q      <= is_eof;
                last_addr_q <= addr_q;
            end

            unique case (state_q)
                StIdle: begin
                    if (start_in) begin
                        state_q <= StRead;
                        x_q     <= '0;
                        y_q     <= '0;
                        addr_q  <= '0;
                    end
                end
                StRead: begin
                    if (issue) begin
                        if (is_eof) begin
                            // Counters freeze on the final pixel.
                            state_q <= StDrain;
                        end else if (is_eol) begin
                            x_q    <= '0;
                            y_q    <= y_q + ADDR_W'(1);
                            addr_q <= addr_q + ADDR_W'(1);
                        end else begin
                            x_q    <= x_q + ADDR_W'(1);
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                StDrain: begin
                    // Leave as the last pixel pops so done follows it directly.
                    if (cnt_d == '0) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Return FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; the pointers define what is live.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{
                data: rd_data_in,
                x:    fx_q,
                y:    fy_q,
                sof:  fsof_q,
                eol:  feol_q,
                eof:  feof_q
            };
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        head          = mem_q[rd_ptr_q];
        pix_valid_out = (cnt_q != '0);

        // Stream fields are forced to zero when nothing is presented.
        pix_out     = pix_valid_out ? head.data : '0;
        x_index_out = pix_valid_out ? head.x    : '0;
        y_index_out = pix_valid_out ? head.y    : '0;
        sof_out     = pix_valid_out && head.sof;
        eol_out     = pix_valid_out && head.eol;
        eof_out     = pix_valid_out && head.eof;

        rd_en_out   = issue;
        rd_addr_out = issue ? addr_q : last_addr_q;

        busy_out = (state_q == StRead) || (state_q == StDrain);
        done_out = (state_q == StDone);
    end

    assert property (@(posedge clk_in) disable iff (rst_in)
        !(push && !pop && (cnt_q == CNT_FULL)));

endmodule
